// File: rtl/ddr3_init_pkg.sv
// ddr3_init_pkg: state encoding, PHY command encodings and mode-register bank numbers for the DDR3 init sequencer
package ddr3_init_pkg;

    typedef enum logic [3:0] {
        S_RST_HOLD, S_CKE_WAIT, S_TXPR, S_MR2, S_MR3, S_MR1, S_MR0, S_ZQCL, S_CMD_WAIT, S_DONE
    } state_t;

    localparam logic [1:0] CMD_NOP  = 2'd0;
    localparam logic [1:0] CMD_MRS  = 2'd1;
    localparam logic [1:0] CMD_ZQCL = 2'd2;

    localparam logic [2:0] BA_MR0 = 3'd0;
    localparam logic [2:0] BA_MR1 = 3'd1;
    localparam logic [2:0] BA_MR2 = 3'd2;
    localparam logic [2:0] BA_MR3 = 3'd3;

    // ZQCL long calibration: A10 high, everything else low
    localparam logic [15:0] ZQCL_ADDR = 16'h0400;

    function automatic int max_int(input int a, input int b);
        return a > b ? a : b;
    endfunction

endpackage

// File: rtl/ddr3_init_timer.sv
// ddr3_init_timer: shared down-counter for every wait interval; load N-1 on entry, zero marks the last cycle
module ddr3_init_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // reload on demand, otherwise count down and park at zero
    always_ff @(posedge clk) begin
        if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ddr3_init_sequencer.sv
// ddr3_init_sequencer: DDR3 power-up sequence (RESET#, CKE, MR2/MR3/MR1/MR0, optional ZQCL via DDR3_INIT_ZQCL_EN)
module ddr3_init_sequencer
    import ddr3_init_pkg::*;
#(
    parameter int          CLK_FREQ_HZ = 100_000_000,
    parameter int          T_RESET_US  = 200,
    parameter int          T_CKE_US    = 500,
    parameter int          TXPR_CYC    = 128,
    parameter int          TMRD_CYC    = 4,
    parameter int          TMOD_CYC    = 12,
    parameter int          TZQINIT_CYC = 512,
    parameter logic [15:0] MR0_VAL     = 16'h0000,
    parameter logic [15:0] MR1_VAL     = 16'h0000,
    parameter logic [15:0] MR2_VAL     = 16'h0000,
    parameter logic [15:0] MR3_VAL     = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ddr_reset_n,
    output logic        ddr_cke,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [1:0]  cmd_type,
    output logic [2:0]  cmd_ba,
    output logic [15:0] cmd_addr,
    output logic        init_done
);

    localparam int CYC_PER_US = CLK_FREQ_HZ / 1_000_000;
    localparam int RST_CYC    = T_RESET_US * CYC_PER_US;
    localparam int CKE_CYC    = T_CKE_US * CYC_PER_US;
    localparam int MAXC       = max_int(max_int(max_int(RST_CYC, CKE_CYC), max_int(TXPR_CYC, TMRD_CYC)),
                                        max_int(TMOD_CYC, TZQINIT_CYC));
    localparam int CW         = $clog2(MAXC) + 1;

    localparam logic [CW-1:0] LD_RST  = CW'(RST_CYC - 1);
    localparam logic [CW-1:0] LD_CKE  = CW'(CKE_CYC - 1);
    localparam logic [CW-1:0] LD_TXPR = CW'(TXPR_CYC - 1);
    localparam logic [CW-1:0] LD_TMRD = CW'(TMRD_CYC - 1);
    localparam logic [CW-1:0] LD_TMOD = CW'(TMOD_CYC - 1);
`ifdef DDR3_INIT_ZQCL_EN
    localparam logic [CW-1:0] LD_TZQ  = CW'(TZQINIT_CYC - 1);
    localparam state_t AFTER_MR0 = S_ZQCL;
`else
    localparam state_t AFTER_MR0 = S_DONE;
`endif

    state_t          state, nxt, tgt, after;
    logic            fire, load, zero;
    logic [CW-1:0]   load_val;
    logic [1:0]      issue_type;
    logic [2:0]      issue_ba;
    logic [15:0]     issue_addr;

    assign fire  = cmd_valid && cmd_ready;
    // command state to enter when the current wait expires
    assign tgt   = state == S_TXPR ? S_MR2 : nxt;
    // step that follows the command being fired
    assign after = state == S_MR2 ? S_MR3 :
                   state == S_MR3 ? S_MR1 :
                   state == S_MR1 ? S_MR0 :
                   state == S_MR0 ? AFTER_MR0 : S_DONE;

`ifdef DDR3_INIT_ZQCL_EN
    assign issue_type = tgt == S_DONE ? CMD_NOP : tgt == S_ZQCL ? CMD_ZQCL : CMD_MRS;
`else
    assign issue_type = tgt == S_DONE ? CMD_NOP : CMD_MRS;
`endif
    assign issue_ba   = tgt == S_MR3 ? BA_MR3 : tgt == S_MR2 ? BA_MR2 : tgt == S_MR1 ? BA_MR1 : BA_MR0;
    assign issue_addr = tgt == S_MR0  ? MR0_VAL :
                        tgt == S_MR1  ? MR1_VAL :
                        tgt == S_MR2  ? MR2_VAL :
                        tgt == S_MR3  ? MR3_VAL :
                        tgt == S_ZQCL ? ZQCL_ADDR : 16'h0000;

    // timer reload: on reset, on leaving a timed reset phase, and on every command fire
    always_comb begin
        load     = rst || fire || (zero && (state == S_RST_HOLD || state == S_CKE_WAIT));
        load_val = rst                  ? LD_RST  :
                   state == S_RST_HOLD  ? LD_CKE  :
                   state == S_CKE_WAIT  ? LD_TXPR :
                   state == S_MR0       ? LD_TMOD :
`ifdef DDR3_INIT_ZQCL_EN
                   state == S_ZQCL      ? LD_TZQ  :
`endif
                   LD_TMRD;
    end

    ddr3_init_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .load     (load),
        .load_val (load_val),
        .zero     (zero)
    );

    // sequencer FSM with registered pin and command outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_RST_HOLD;
            nxt         <= S_MR2;
            ddr_reset_n <= 1'b0;
            ddr_cke     <= 1'b0;
            cmd_valid   <= 1'b0;
            cmd_type    <= CMD_NOP;
            cmd_ba      <= '0;
            cmd_addr    <= '0;
            init_done   <= 1'b0;
        end else if (fire) begin
            state     <= S_CMD_WAIT;
            nxt       <= after;
            cmd_valid <= 1'b0;
            cmd_type  <= CMD_NOP;
            cmd_ba    <= '0;
            cmd_addr  <= '0;
        end else if (zero) begin
            case (state)
                S_RST_HOLD: begin
                    state       <= S_CKE_WAIT;
                    ddr_reset_n <= 1'b1;
                end
                S_CKE_WAIT: begin
                    state   <= S_TXPR;
                    ddr_cke <= 1'b1;
                end
                S_TXPR, S_CMD_WAIT: begin
                    state     <= tgt;
                    init_done <= tgt == S_DONE;
                    cmd_valid <= tgt != S_DONE;
                    cmd_type  <= issue_type;
                    cmd_ba    <= issue_ba;
                    cmd_addr  <= issue_addr;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_init_sequencer.sv
// tb_ddr3_init_sequencer: directed bench for ddr3_init_sequencer (expectations follow DDR3_INIT_ZQCL_EN)
module tb_ddr3_init_sequencer;

    localparam logic [15:0] MR0 = 16'h1D70;
    localparam logic [15:0] MR1 = 16'h0006;
    localparam logic [15:0] MR2 = 16'h0018;
    localparam logic [15:0] MR3 = 16'h0004;
`ifdef DDR3_INIT_ZQCL_EN
    localparam bit ZQ = 1'b1;
`else
    localparam bit ZQ = 1'b0;
`endif
    localparam int EXP_NF   = ZQ ? 5 : 4;
    localparam int EXP_DONE = ZQ ? 64 : 43;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_ready = 1'b1;
    logic        ddr_reset_n, ddr_cke, cmd_valid, init_done;
    logic [1:0]  cmd_type;
    logic [2:0]  cmd_ba;
    logic [15:0] cmd_addr;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    int          nf, rn_cyc, cke_cyc, done_cyc;
    bit          bad_cke, nop_bad, zq_seen, unstable, held;
    logic [1:0]  p_type;
    logic [2:0]  p_ba;
    logic [15:0] p_addr;
    int          fcyc  [8];
    int          fba   [8];
    int          ftype [8];
    logic [15:0] faddr [8];

    int          e_cyc  [5] = '{15, 20, 25, 30, 43};
    int          e_ba   [5] = '{2, 3, 1, 0, 0};
    int          e_type [5] = '{1, 1, 1, 1, 2};
    logic [15:0] e_addr [5] = '{MR2, MR3, MR1, MR0, 16'h0400};

    ddr3_init_sequencer #(
        .CLK_FREQ_HZ (1_000_000),
        .T_RESET_US  (4),
        .T_CKE_US    (6),
        .TXPR_CYC    (5),
        .TMRD_CYC    (4),
        .TMOD_CYC    (12),
        .TZQINIT_CYC (20),
        .MR0_VAL     (MR0),
        .MR1_VAL     (MR1),
        .MR2_VAL     (MR2),
        .MR3_VAL     (MR3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ddr_reset_n (ddr_reset_n),
        .ddr_cke     (ddr_cke),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_type    (cmd_type),
        .cmd_ba      (cmd_ba),
        .cmd_addr    (cmd_addr),
        .init_done   (init_done)
    );

    always #5 clk = ~clk;

    // cycle number: values observed after the k-th post-reset edge belong to cycle k+1
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    // observe outputs mid-cycle and log events for the test tasks
    always @(negedge clk) begin
        if (!rst) begin
            if (ddr_cke && !ddr_reset_n) bad_cke = 1'b1;
            if (ddr_reset_n && rn_cyc < 0) rn_cyc = cyc;
            if (ddr_cke && cke_cyc < 0) cke_cyc = cyc;
            if (init_done && done_cyc < 0) done_cyc = cyc;
            if (cmd_type == 2'd2) zq_seen = 1'b1;
            if (!cmd_valid && (cmd_type != 2'd0 || cmd_ba != 3'd0 || cmd_addr != 16'd0)) nop_bad = 1'b1;
            if (held && !(cmd_valid && cmd_type == p_type && cmd_ba == p_ba && cmd_addr == p_addr)) unstable = 1'b1;
            held   = cmd_valid && !cmd_ready;
            p_type = cmd_type;
            p_ba   = cmd_ba;
            p_addr = cmd_addr;
            if (cmd_valid && cmd_ready && nf < 8) begin
                fcyc[nf]  = cyc;
                fba[nf]   = int'(cmd_ba);
                ftype[nf] = int'(cmd_type);
                faddr[nf] = cmd_addr;
                nf++;
            end
        end
    end

    task automatic clear_log();
        nf = 0; rn_cyc = -1; cke_cyc = -1; done_cyc = -1;
        bad_cke = 0; nop_bad = 0; zq_seen = 0; unstable = 0; held = 0;
        for (int i = 0; i < 8; i++) begin
            fcyc[i] = -1; fba[i] = -1; ftype[i] = -1; faddr[i] = 16'hxxxx;
        end
    endtask

    task automatic restart();
        @(posedge clk); #2; rst = 1'b1;
        @(posedge clk); #2; clear_log(); rst = 1'b0;
    endtask

    // drive cmd_ready low during cycles [lo, hi) and run until init_done or budget
    task automatic run_until_done(input int budget, input int lo, input int hi);
        int n;
        n = 0;
        while (done_cyc < 0 && n < budget) begin
            @(posedge clk); #2;
            cmd_ready = !(cyc >= lo && cyc < hi);
            n++;
        end
        @(negedge clk);
        tests++; if (done_cyc < 0) begin fails++; $display("FAIL timeout: init_done not seen within %0d cycles", budget); end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (ddr_reset_n !== 1'b0) begin fails++; $display("FAIL rst_reset_n got %b exp 0", ddr_reset_n); end
        tests++; if (ddr_cke !== 1'b0) begin fails++; $display("FAIL rst_cke got %b exp 0", ddr_cke); end
        tests++; if (cmd_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b exp 0", cmd_valid); end
        tests++; if (cmd_type !== 2'd0) begin fails++; $display("FAIL rst_type got %0d exp 0", cmd_type); end
        tests++; if (cmd_ba !== 3'd0) begin fails++; $display("FAIL rst_ba got %0d exp 0", cmd_ba); end
        tests++; if (cmd_addr !== 16'd0) begin fails++; $display("FAIL rst_addr got %h exp 0000", cmd_addr); end
        tests++; if (init_done !== 1'b0) begin fails++; $display("FAIL rst_done got %b exp 0", init_done); end
    endtask

    task automatic test_sequence();
        restart();
        run_until_done(200, 0, 0);
        tests++; if (rn_cyc !== 4) begin fails++; $display("FAIL seq_reset_n_rise got %0d exp 4", rn_cyc); end
        tests++; if (cke_cyc !== 10) begin fails++; $display("FAIL seq_cke_rise got %0d exp 10", cke_cyc); end
        tests++; if (nf !== EXP_NF) begin fails++; $display("FAIL seq_fire_count got %0d exp %0d", nf, EXP_NF); end
        for (int i = 0; i < EXP_NF; i++) begin
            tests++; if (fcyc[i] !== e_cyc[i]) begin fails++; $display("FAIL seq_fire%0d_cycle got %0d exp %0d", i, fcyc[i], e_cyc[i]); end
            tests++; if (fba[i] !== e_ba[i]) begin fails++; $display("FAIL seq_fire%0d_ba got %0d exp %0d", i, fba[i], e_ba[i]); end
            tests++; if (ftype[i] !== e_type[i]) begin fails++; $display("FAIL seq_fire%0d_type got %0d exp %0d", i, ftype[i], e_type[i]); end
            tests++; if (faddr[i] !== e_addr[i]) begin fails++; $display("FAIL seq_fire%0d_addr got %h exp %h", i, faddr[i], e_addr[i]); end
        end
        tests++; if (done_cyc !== EXP_DONE) begin fails++; $display("FAIL seq_done_cycle got %0d exp %0d", done_cyc, EXP_DONE); end
        tests++; if (bad_cke !== 1'b0) begin fails++; $display("FAIL seq_cke_before_reset_n got %b exp 0", bad_cke); end
        tests++; if (nop_bad !== 1'b0) begin fails++; $display("FAIL seq_idle_fields_nonzero got %b exp 0", nop_bad); end
        tests++; if (zq_seen !== ZQ) begin fails++; $display("FAIL seq_zqcl_type_seen got %b exp %b", zq_seen, ZQ); end
        repeat (10) @(negedge clk);
        tests++; if (init_done !== 1'b1) begin fails++; $display("FAIL seq_done_sticky got %b exp 1", init_done); end
        tests++; if (cmd_valid !== 1'b0) begin fails++; $display("FAIL seq_done_valid got %b exp 0", cmd_valid); end
    endtask

    task automatic test_backpressure();
        restart();
        run_until_done(200, 20, 27);
        tests++; if (nf !== EXP_NF) begin fails++; $display("FAIL bp_fire_count got %0d exp %0d", nf, EXP_NF); end
        tests++; if (fcyc[1] !== 27) begin fails++; $display("FAIL bp_mr3_cycle got %0d exp 27", fcyc[1]); end
        tests++; if (fba[1] !== 3) begin fails++; $display("FAIL bp_mr3_ba got %0d exp 3", fba[1]); end
        tests++; if (faddr[1] !== MR3) begin fails++; $display("FAIL bp_mr3_addr got %h exp %h", faddr[1], MR3); end
        tests++; if (unstable !== 1'b0) begin fails++; $display("FAIL bp_hold_stable got %b exp 0", unstable); end
        tests++; if (fcyc[2] !== 32) begin fails++; $display("FAIL bp_mr1_cycle got %0d exp 32", fcyc[2]); end
        tests++; if (fba[2] !== 1) begin fails++; $display("FAIL bp_mr1_ba got %0d exp 1", fba[2]); end
        tests++; if (faddr[2] !== MR1) begin fails++; $display("FAIL bp_mr1_addr got %h exp %h", faddr[2], MR1); end
        tests++; if (fcyc[3] !== 37) begin fails++; $display("FAIL bp_mr0_cycle got %0d exp 37", fcyc[3]); end
        tests++; if (fba[3] !== 0) begin fails++; $display("FAIL bp_mr0_ba got %0d exp 0", fba[3]); end
        tests++; if (faddr[3] !== MR0) begin fails++; $display("FAIL bp_mr0_addr got %h exp %h", faddr[3], MR0); end
        tests++; if (done_cyc !== (ZQ ? 71 : 50)) begin fails++; $display("FAIL bp_done_cycle got %0d exp %0d", done_cyc, ZQ ? 71 : 50); end
    endtask

    task automatic test_mid_reset();
        int n, nf_before;
        restart();
        n = 0;
        while (cyc != 28 && n < 100) begin
            @(posedge clk); #2;
            cmd_ready = cyc < 25;
            n++;
        end
        tests++; if (cyc !== 28) begin fails++; $display("FAIL mr_reach_cycle got %0d exp 28", cyc); end
        rst = 1'b1; cmd_ready = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        nf_before = nf;
        clear_log();
        @(negedge clk);
        tests++; if (nf_before !== 2) begin fails++; $display("FAIL mr_fires_before got %0d exp 2", nf_before); end
        tests++; if (cmd_valid !== 1'b0) begin fails++; $display("FAIL mr_valid got %b exp 0", cmd_valid); end
        tests++; if ({ddr_reset_n, ddr_cke, init_done} !== 3'b000) begin fails++; $display("FAIL mr_pins got %b exp 000", {ddr_reset_n, ddr_cke, init_done}); end
        tests++; if ({cmd_type, cmd_ba, cmd_addr} !== 21'd0) begin fails++; $display("FAIL mr_cmd_fields got %h exp 0", {cmd_type, cmd_ba, cmd_addr}); end
        run_until_done(200, 0, 0);
        tests++; if (rn_cyc !== 4) begin fails++; $display("FAIL mr_replay_reset_n got %0d exp 4", rn_cyc); end
        tests++; if (cke_cyc !== 10) begin fails++; $display("FAIL mr_replay_cke got %0d exp 10", cke_cyc); end
        tests++; if (fcyc[0] !== 15 || fba[0] !== 2) begin fails++; $display("FAIL mr_replay_first got cyc %0d ba %0d exp cyc 15 ba 2", fcyc[0], fba[0]); end
        tests++; if (nf !== EXP_NF) begin fails++; $display("FAIL mr_replay_count got %0d exp %0d", nf, EXP_NF); end
        tests++; if (done_cyc !== EXP_DONE) begin fails++; $display("FAIL mr_replay_done got %0d exp %0d", done_cyc, EXP_DONE); end
    endtask

    initial begin
        clear_log();
        test_reset();
        test_sequence();
        test_backpressure();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ddr3_init_sequencer.md
# ddr3_init_sequencer

Power-up initialisation sequencer for the DDR3 device, clocked in the DRAM sync domain directly downstream of the clock/reset generator. Runs once each time the domain reset deasserts, which the generator does after its PLL lock and 600–700 µs hold. Drives DDR3 RESET# and CKE through the JEDEC wait intervals, then issues MR2, MR3, MR1, MR0 and ZQCL to the PHY command path over a valid/ready handshake. Asserts `init_done` to release the controller.

## Interface
Parameters:
- `CLK_FREQ_HZ`, 100_000_000: domain clock frequency; `CYC_PER_US = CLK_FREQ_HZ/1_000_000` (integer, ≥1).
- `T_RESET_US`, 200: RESET# low time.
- `T_CKE_US`, 500: RESET# high to CKE high.
- `TXPR_CYC`, 128: CKE high to first MRS.
- `TMRD_CYC`, 4: MRS to next MRS.
- `TMOD_CYC`, 12: MR0 to next command.
- `TZQINIT_CYC`, 512: ZQCL duration.
- `MR0_VAL`, `MR1_VAL`, `MR2_VAL`, `MR3_VAL`, 16'h0000 each: 16-bit mode register contents.

Ports:
- `clk` in 1: DRAM sync domain clock.
- `rst` in 1: synchronous, active-high reset.
- `ddr_reset_n` out 1: DDR3 RESET#.
- `ddr_cke` out 1: DDR3 CKE.
- `cmd_valid` out 1: command request.
- `cmd_ready` in 1: PHY accepts the command.
- `cmd_type` out 2: 0 NOP, 1 MRS, 2 ZQCL.
- `cmd_ba` out 3: bank address.
- `cmd_addr` out 16: address bus.
- `init_done` out 1: sequence complete, sticky until `rst`.

## Operation
- States: `S_RST_HOLD`, `S_CKE_WAIT`, `S_TXPR`, `S_MR2`, `S_MR3`, `S_MR1`, `S_MR0`, `S_ZQCL`, `S_CMD_WAIT`, `S_DONE`.
- `S_RST_HOLD`: `ddr_reset_n`=0, `ddr_cke`=0. Lasts `T_RESET_US*CYC_PER_US` cycles, then `S_CKE_WAIT` with `ddr_reset_n`=1.
- `S_CKE_WAIT`: lasts `T_CKE_US*CYC_PER_US` cycles, then `S_TXPR` with `ddr_cke`=1.
- `S_TXPR`: lasts `TXPR_CYC` cycles, then `S_MR2`.
- `S_MRn`: `cmd_valid`=1, `cmd_type`=MRS, `cmd_ba`=n, `cmd_addr`=`MRn_VAL`. All four are held stable until the cycle `cmd_valid && cmd_ready`. After the fire, go to `S_CMD_WAIT`, which lasts `TMRD_CYC` cycles, or `TMOD_CYC` cycles after MR0. Then take the next state in the order MR2→MR3→MR1→MR0→ZQCL.
- `S_ZQCL`: `cmd_type`=ZQCL, `cmd_ba`=0, `cmd_addr[10]`=1, all other address bits 0. After the fire, wait `TZQINIT_CYC` cycles, then `S_DONE`.
- `S_DONE`: `init_done`=1 and `cmd_valid`=0. Terminal state.
- When not firing, `cmd_type`=NOP, `cmd_ba`=0, `cmd_addr`=0.
- `cmd_ready` is ignored while `cmd_valid`=0.
- `rst` asserted in any state, including mid-handshake: next cycle all outputs take reset values, state goes to `S_RST_HOLD`, counter reloads. A pending command is dropped without firing.

## Timing
- Reset values: `ddr_reset_n`=0, `ddr_cke`=0, `cmd_valid`=0, `cmd_type`=0, `cmd_ba`=0, `cmd_addr`=0, `init_done`=0.
- All outputs are registered.
- Cycle 0 is the first rising edge with `rst`=0.
- `ddr_reset_n` rises at the edge ending cycle `T_RESET_US*CYC_PER_US - 1`.
- Each later wait of N cycles ends exactly N edges after the edge that entered it.
- `cmd_valid` rises on the edge that ends `S_TXPR` or `S_CMD_WAIT`.
- `cmd_valid` falls on the edge after the fire cycle; that edge also enters `S_CMD_WAIT`.
- The single down-counter is sized `$clog2` of the largest cycle count plus 1, and is loaded with N-1 on state entry.

## Configuration
- `DDR3_INIT_ZQCL_EN` defined: the ZQCL step and its `TZQINIT_CYC` wait are included.
- Undefined: after the MR0 `TMOD_CYC` wait, go straight to `S_DONE`. `cmd_type`=2 is never produced.

## Structure
- Package `ddr3_init_pkg`: state enum, `cmd_type` encodings (`CMD_NOP`, `CMD_MRS`, `CMD_ZQCL`), MR bank constants (MR0=0 … MR3=3).
- Sub-module `ddr3_init_timer`: inputs `load` and `load_val`; output `zero`. Shared by all wait states.

## Test plan
Common parameters: `CLK_FREQ_HZ`=1_000_000, `T_RESET_US`=4, `T_CKE_US`=6, `TXPR_CYC`=5, `TMRD_CYC`=4, `TMOD_CYC`=12, `TZQINIT_CYC`=20.

- Release `rst`, `cmd_ready` tied 1 → `ddr_reset_n` rises at cycle 4 and `ddr_cke` rises at cycle 10. First MRS has `cmd_ba`=2 at cycle 15. Commands fire in order ba 2,3,1,0, spaced 5,5,5 cycles. ZQCL follows MR0 by 13 cycles with `cmd_addr`=16'h0400. `init_done` is set 21 cycles after ZQCL.
- Hold `cmd_ready`=0 for 7 cycles during MR3 → `cmd_valid`, `cmd_ba`=3 and `cmd_addr`=`MR3_VAL` stay stable. MR1 issues exactly 5 cycles after the late fire.
- `MR0_VAL`=16'h1D70, `MR1_VAL`=16'h0006 → the values appear on `cmd_addr` with `cmd_ba` 0 and 1 respectively.
- Assert `rst` for 1 cycle while MR1 is pending → no fire. All outputs are 0 next cycle, and the full sequence replays from cycle 0.
- Build without `DDR3_INIT_ZQCL_EN` → `init_done` is set 13 cycles after the MR0 fire. `cmd_type` never equals 2.
- Check from reset through `S_DONE`: `init_done`=0 before completion, and `ddr_cke` never rises while `ddr_reset_n`=0.
